// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter (CPU, AXI) for a single-port data RAM.
// Grants are combinational; read data returns one cycle after the grant.
module dmem_port_arbiter #(
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_halted,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        axi_req,
  input  logic        axi_we,
  input  logic [11:0] axi_addr,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_gnt,
  output logic        axi_rvalid,
  output logic [31:0] axi_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [15:0] cpu_stall_cnt
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_CPU_RUN);

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_cmd_t;

  logic [3:0]  run_cnt;
  logic        own_cpu, own_axi;
  logic [31:0] cpu_rdata_q, axi_rdata_q;
  mem_cmd_t    cmd;

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    cpu_gnt = 1'b0;
    axi_gnt = 1'b0;
    if (rst_n) begin
      if (cpu_req && axi_req) begin
        if (cpu_halted || run_cnt == RUN_MAX) axi_gnt = 1'b1;
        else                                  cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        axi_gnt = axi_req;
      end
    end
  end

  always_comb begin
    cmd = '0;
    if (cpu_gnt)      cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
    else if (axi_gnt) cmd = '{we: axi_we, addr: axi_addr, wdata: axi_wdata, wstrb: axi_wstrb};
  end

  assign mem_en    = cpu_gnt | axi_gnt;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_wstrb = cmd.wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt       <= '0;
      own_cpu       <= 1'b0;
      own_axi       <= 1'b0;
      cpu_rdata_q   <= '0;
      axi_rdata_q   <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      if (!axi_req || axi_gnt)                 run_cnt <= '0;
      else if (cpu_gnt && run_cnt != RUN_MAX)  run_cnt <= run_cnt + 4'd1;
      own_cpu <= cpu_gnt & ~cpu_we;
      own_axi <= axi_gnt & ~axi_we;
      if (own_cpu) cpu_rdata_q <= mem_rdata;
      if (own_axi) axi_rdata_q <= mem_rdata;
      if (cpu_req && !cpu_gnt && cpu_stall_cnt != 16'hFFFF)
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end

  // Owner sees RAM data directly in the return cycle; everyone else keeps the last return.
  assign cpu_rvalid = own_cpu;
  assign axi_rvalid = own_axi;
  assign cpu_rdata  = own_cpu ? mem_rdata : cpu_rdata_q;
  assign axi_rdata  = own_axi ? mem_rdata : axi_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-strobed RAM model and
// read-return scoreboards per requester.
module tb_dmem_port_arbiter;
  logic        clk, rst_n, cpu_halted;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        axi_req, axi_we, axi_gnt, axi_rvalid;
  logic [11:0] axi_addr;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] cpu_stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] axi_q[$];
  logic [31:0] ram [0:4095];

  dmem_port_arbiter #(.MAX_CPU_RUN(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_halted(cpu_halted),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .axi_req(axi_req), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_gnt(axi_gnt), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .cpu_stall_cnt(cpu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: byte-strobed write, registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every read return is matched against the oldest expected word.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
      else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (axi_rvalid) begin
      if (axi_q.size() == 0) chk("axi_rvalid_unexpected", 32'(axi_rvalid), 32'd0);
      else chk("axi_rdata", axi_rdata, axi_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cpu(input bit r, input bit w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
  endtask

  task automatic set_axi(input bit r, input bit w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    axi_req = r; axi_we = w; axi_addr = a; axi_wdata = d; axi_wstrb = s;
  endtask

  task automatic chk_g(input string nm, input bit c, input bit a);
    @(negedge clk);
    chk({nm, "_cpu_gnt"}, 32'(cpu_gnt), 32'(c));
    chk({nm, "_axi_gnt"}, 32'(axi_gnt), 32'(a));
    chk({nm, "_mem_en"},  32'(mem_en),  32'(c | a));
  endtask

  string pat;

  initial begin
    ram[12'h010] = 32'hDEADBEEF;
    ram[12'h020] = 32'hAABBCCDD;
    mem_rdata = '0;
    rst_n = 1'b0; cpu_halted = 1'b0;
    set_cpu(1, 0, 12'h010, 0, 0);
    set_axi(1, 0, 12'h020, 0, 0);

    // Reset: requests present but nothing may be granted or counted.
    repeat (2) @(posedge clk);
    chk_g("reset", 0, 0);
    chk("reset_stall", 32'(cpu_stall_cnt), 0);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_rvalid", 32'({cpu_rvalid, axi_rvalid}), 0);
    #1;
    set_cpu(0, 0, 0, 0, 0); set_axi(0, 0, 0, 0, 0);
    step(); rst_n = 1'b1; step();

    // CPU read only.
    set_cpu(1, 0, 12'h010, 0, 0); cpu_q.push_back(32'hDEADBEEF);
    chk_g("cpu_rd", 1, 0);
    chk("cpu_rd_addr", 32'(mem_addr), 32'h010);
    step(); set_cpu(0, 0, 0, 0, 0); step();

    // AXI partial write then CPU read of the merged word.
    set_axi(1, 1, 12'h020, 32'h12345678, 4'b0011);
    chk_g("axi_wr", 0, 1);
    chk("axi_wr_strb", 32'(mem_wstrb), 32'h3);
    chk("axi_wr_data", mem_wdata, 32'h12345678);
    step(); set_axi(0, 0, 0, 0, 0);
    set_cpu(1, 0, 12'h020, 0, 0); cpu_q.push_back(32'hAABB5678);
    chk_g("cpu_rd_merge", 1, 0);
    step(); set_cpu(0, 0, 0, 0, 0); step();
    chk("stall_zero", 32'(cpu_stall_cnt), 0);

    // Continuous contention: four CPU slots then one AXI slot.
    set_cpu(1, 1, 12'h100, 32'h11, 4'hF);
    set_axi(1, 1, 12'h200, 32'h22, 4'hF);
    pat = "CCCCACCCCA";
    for (int i = 0; i < 10; i++) begin
      chk_g($sformatf("rr%0d", i), pat[i] == "C", pat[i] == "A");
      chk($sformatf("rr%0d_addr", i), 32'(mem_addr), pat[i] == "C" ? 32'h100 : 32'h200);
      step();
    end
    set_cpu(0, 0, 0, 0, 0); set_axi(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_mem_idle", 32'({mem_en, mem_we, mem_addr}), 0);
    chk("rr_stall", 32'(cpu_stall_cnt), 2);
    step();

    // Halted CPU: AXI wins from the very cycle halted rises.
    cpu_halted = 1'b1;
    set_cpu(1, 1, 12'h100, 32'h33, 4'hF);
    set_axi(1, 0, 12'h010, 0, 0); axi_q.push_back(32'hDEADBEEF);
    chk_g("halt0", 0, 1);
    step(); set_axi(1, 1, 12'h300, 32'h44, 4'hF);
    chk_g("halt1", 0, 1); step();
    chk_g("halt2", 0, 1); step();
    set_axi(0, 0, 0, 0, 0);
    chk_g("halt_axi_drop", 1, 0);
    step(); set_cpu(0, 0, 0, 0, 0); cpu_halted = 1'b0;
    @(negedge clk);
    chk("halt_stall", 32'(cpu_stall_cnt), 5);
    step();

    // Back-to-back CPU reads, then check non-owner hold.
    set_cpu(1, 0, 12'h010, 0, 0); cpu_q.push_back(32'hDEADBEEF);
    chk_g("b2b0", 1, 0); step();
    set_cpu(1, 0, 12'h020, 0, 0); cpu_q.push_back(32'hAABB5678);
    chk_g("b2b1", 1, 0); step();
    set_cpu(0, 0, 0, 0, 0); step();
    @(negedge clk);
    chk("hold_cpu_rdata", cpu_rdata, 32'hAABB5678);
    chk("hold_axi_rdata", axi_rdata, 32'hDEADBEEF);
    chk("hold_rvalid", 32'({cpu_rvalid, axi_rvalid}), 0);
    step();

    // Reset in the return cycle of a read: the return must vanish.
    set_cpu(1, 0, 12'h010, 0, 0);
    chk_g("rst_rd", 1, 0);
    step(); set_cpu(0, 0, 0, 0, 0); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_mid_rdata", cpu_rdata, 0);
    chk("rst_mid_axi_rdata", axi_rdata, 0);
    chk("rst_mid_stall", 32'(cpu_stall_cnt), 0);
    step(); rst_n = 1'b1;
    set_cpu(1, 1, 12'h100, 32'h55, 4'hF);
    chk_g("post_rst_first", 1, 0);
    chk("post_rst_rvalid", 32'(cpu_rvalid), 0);
    step(); set_cpu(0, 0, 0, 0, 0); step();
    @(negedge clk);
    chk("post_rst_rvalid2", 32'(cpu_rvalid), 0);
    step();

    // Long starvation: counter must reach and stick at all-ones.
    cpu_halted = 1'b1;
    set_cpu(1, 0, 12'h010, 0, 0);
    set_axi(1, 1, 12'h300, 32'h66, 4'hF);
    repeat (65534) step();
    @(negedge clk);
    chk("stall_fffe", 32'(cpu_stall_cnt), 32'hFFFE);
    step();
    repeat (4465) step();
    @(negedge clk);
    chk("stall_sat", 32'(cpu_stall_cnt), 32'hFFFF);
    step();
    set_cpu(0, 0, 0, 0, 0); set_axi(0, 0, 0, 0, 0); cpu_halted = 1'b0;
    repeat (2) step();

    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    chk("axi_q_drained", 32'(axi_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
